// File: rtl/morse_rx_decoder_pkg.sv
// Shared Morse definitions: receiver FSM states, special char codes,
// unit thresholds and the ITU A-Z pattern decode used by both RX and TX.
// Pattern encoding: pat[3:0] is left-justified, first symbol in pat[3],
// 1 = dot, 0 = dash; unused low bits are zero.
package morse_rx_decoder_pkg;

  localparam int unsigned CODE_W     = 5;
  localparam int unsigned PAT_W      = 4;
  localparam int unsigned LEN_W      = 3;
  localparam int unsigned UNIT_CNT_W = 3;

  localparam logic [CODE_W-1:0] CHAR_SPACE = 5'd0;
  localparam logic [CODE_W-1:0] CHAR_ERR   = 5'd31;

  localparam int unsigned DOT_MAX_UNITS    = 2;
  localparam int unsigned LETTER_GAP_UNITS = 3;
  localparam int unsigned WORD_GAP_UNITS   = 7;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_MARK  = 2'd1,
    ST_SPACE = 2'd2,
    ST_GAP   = 2'd3
  } morse_state_e;

  // Map {len,pat} to 1..26 for A..Z; anything else is CHAR_ERR.
  function automatic logic [CODE_W-1:0] morse_decode(input logic [LEN_W-1:0] len,
                                                     input logic [PAT_W-1:0] pat);
    logic [CODE_W-1:0] code;
    case ({len, pat})
      {3'd2, 4'b1000}: code = 5'd1;   // A .-
      {3'd4, 4'b0111}: code = 5'd2;   // B -...
      {3'd4, 4'b0101}: code = 5'd3;   // C -.-.
      {3'd3, 4'b0110}: code = 5'd4;   // D -..
      {3'd1, 4'b1000}: code = 5'd5;   // E .
      {3'd4, 4'b1101}: code = 5'd6;   // F ..-.
      {3'd3, 4'b0010}: code = 5'd7;   // G --.
      {3'd4, 4'b1111}: code = 5'd8;   // H ....
      {3'd2, 4'b1100}: code = 5'd9;   // I ..
      {3'd4, 4'b1000}: code = 5'd10;  // J .---
      {3'd3, 4'b0100}: code = 5'd11;  // K -.-
      {3'd4, 4'b1011}: code = 5'd12;  // L .-..
      {3'd2, 4'b0000}: code = 5'd13;  // M --
      {3'd2, 4'b0100}: code = 5'd14;  // N -.
      {3'd3, 4'b0000}: code = 5'd15;  // O ---
      {3'd4, 4'b1001}: code = 5'd16;  // P .--.
      {3'd4, 4'b0010}: code = 5'd17;  // Q --.-
      {3'd3, 4'b1010}: code = 5'd18;  // R .-.
      {3'd3, 4'b1110}: code = 5'd19;  // S ...
      {3'd1, 4'b0000}: code = 5'd20;  // T -
      {3'd3, 4'b1100}: code = 5'd21;  // U ..-
      {3'd4, 4'b1110}: code = 5'd22;  // V ...-
      {3'd3, 4'b1000}: code = 5'd23;  // W .--
      {3'd4, 4'b0110}: code = 5'd24;  // X -..-
      {3'd4, 4'b0100}: code = 5'd25;  // Y -.--
      {3'd4, 4'b0011}: code = 5'd26;  // Z --..
      default:         code = CHAR_ERR;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/morse_rx_decoder_if.sv
// Decoded-character bus from the Morse receiver.
//   char_out   : 1-26 letter, 0 word space, 31 error; held until next strobe
//   char_valid : 1-cycle strobe
//   char_err   : qualifies char_valid
//   rx_active  : letter being accumulated
// master = decoder side (drives), slave = consumer side.
interface morse_rx_decoder_if;
  import morse_rx_decoder_pkg::*;

  logic [CODE_W-1:0] char_out;
  logic              char_valid;
  logic              char_err;
  logic              rx_active;

  modport master (output char_out, output char_valid, output char_err, output rx_active);
  modport slave  (input  char_out, input  char_valid, input  char_err, input  rx_active);
endinterface

// File: rtl/morse_rx_decoder_unit_timer.sv
// Morse unit timer: prescaler 0..TIME_UNIT-1 pulsing unit_tick_c_o at terminal
// count, and a saturating unit counter. clr_i restarts both (line edge).
// Ports: clk, rst_n, clr_i (restart), unit_tick_c_o (combinational tick),
//        unit_cnt_o (registered units since last edge, saturates at 7).
// The tick still fires in a clear cycle so the caller can see a duration that
// ends exactly on a unit boundary; unit_cnt_o shows the pre-tick value then.
module morse_rx_decoder_unit_timer
  import morse_rx_decoder_pkg::*;
#(
  parameter int unsigned TIME_UNIT = 250000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr_i,
  output logic                  unit_tick_c_o,
  output logic [UNIT_CNT_W-1:0] unit_cnt_o
);

  localparam int unsigned PRESC_W = (TIME_UNIT > 1) ? $clog2(TIME_UNIT) : 1;
  localparam logic [UNIT_CNT_W-1:0] UNIT_SAT = '1;

  logic [PRESC_W-1:0]    presc_q;
  logic [UNIT_CNT_W-1:0] unit_cnt_q;
  logic                  terminal;

  assign terminal      = (presc_q == PRESC_W'(TIME_UNIT - 1));
  assign unit_tick_c_o = terminal;
  assign unit_cnt_o    = unit_cnt_q;

  // Prescaler and saturating unit counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q    <= '0;
      unit_cnt_q <= '0;
    end else if (clr_i) begin
      presc_q    <= '0;
      unit_cnt_q <= '0;
    end else begin
      presc_q <= terminal ? '0 : presc_q + PRESC_W'(1);
      if (terminal && (unit_cnt_q != UNIT_SAT)) begin
        unit_cnt_q <= unit_cnt_q + UNIT_CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/morse_rx_decoder.sv
// Morse receive decoder: synchronizes a keyed line, times marks/spaces in
// Morse units, classifies dots/dashes and strobes one code per letter
// (1-26 A-Z, 31 error) followed by a word space code 0 after a long gap.
// Ports: clk, rst_n (async active-low), ena (low = idle and clear letter),
//        morse_in (async keyed line, 1 = mark), rx_if (master: char_out,
//        char_valid, char_err, rx_active).
// Build option: MORSE_RX_GLITCH_FILTER_EN adds a stability filter that only
// accepts a line change after GLITCH_CYCLES consecutive stable cycles.
module morse_rx_decoder
  import morse_rx_decoder_pkg::*;
#(
  parameter int unsigned TIME_UNIT = 250000
`ifdef MORSE_RX_GLITCH_FILTER_EN
  ,
  parameter int unsigned GLITCH_CYCLES = 16
`endif
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                ena,
  input  logic                morse_in,
  morse_rx_decoder_if.master  rx_if
);

  localparam logic [UNIT_CNT_W-1:0] DOT_LIMIT  = UNIT_CNT_W'(DOT_MAX_UNITS);
  localparam logic [UNIT_CNT_W-1:0] LETTER_PRE = UNIT_CNT_W'(LETTER_GAP_UNITS - 1);
  localparam logic [UNIT_CNT_W-1:0] WORD_PRE   = UNIT_CNT_W'(WORD_GAP_UNITS - 1);
  localparam logic [LEN_W-1:0]      LEN_MAX    = LEN_W'(PAT_W);

  // Two-flop synchronizer.
  logic [1:0] sync_q;
  logic       line_s;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= '0;
    else        sync_q <= {sync_q[0], morse_in};
  end
  assign line_s = sync_q[1];

  logic line_f;

`ifdef MORSE_RX_GLITCH_FILTER_EN
  // Accept a change only once it has differed from the filtered level long enough.
  localparam int unsigned GLITCH_W = $clog2(GLITCH_CYCLES + 1);
  logic [GLITCH_W-1:0] glitch_cnt_q;
  logic                line_f_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      glitch_cnt_q <= '0;
      line_f_q     <= 1'b0;
    end else if (line_s == line_f_q) begin
      glitch_cnt_q <= '0;
    end else if (glitch_cnt_q == GLITCH_W'(GLITCH_CYCLES - 1)) begin
      glitch_cnt_q <= '0;
      line_f_q     <= line_s;
    end else begin
      glitch_cnt_q <= glitch_cnt_q + GLITCH_W'(1);
    end
  end
  assign line_f = line_f_q;
`else
  assign line_f = line_s;
`endif

  // Edge detect on the (optionally filtered) line.
  logic line_prev_q;
  logic rise_c, fall_c, edge_c;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) line_prev_q <= 1'b0;
    else        line_prev_q <= line_f;
  end
  assign rise_c = line_f & ~line_prev_q;
  assign fall_c = ~line_f & line_prev_q;
  assign edge_c = rise_c | fall_c;

  logic                  unit_tick_c;
  logic [UNIT_CNT_W-1:0] unit_cnt;

  morse_rx_decoder_unit_timer #(
    .TIME_UNIT (TIME_UNIT)
  ) u_timer (
    .clk           (clk),
    .rst_n         (rst_n),
    .clr_i         (edge_c),
    .unit_tick_c_o (unit_tick_c),
    .unit_cnt_o    (unit_cnt)
  );

  morse_state_e      state_q, state_d;
  logic [PAT_W-1:0]  pat_q, pat_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic              ovf_q, ovf_d;
  logic [CODE_W-1:0] char_out_q, char_out_d;
  logic              char_valid_q, char_valid_d;
  logic              char_err_q, char_err_d;
  logic              rx_active_q, rx_active_d;
  logic [1:0]        sym_idx;
  logic [CODE_W-1:0] letter_code;

  // Next free slot in the left-justified pattern.
  assign sym_idx     = 2'(3'd3 - len_q);
  assign letter_code = ovf_q ? CHAR_ERR : morse_decode(len_q, pat_q);

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      pat_q        <= '0;
      len_q        <= '0;
      ovf_q        <= 1'b0;
      char_out_q   <= CHAR_SPACE;
      char_valid_q <= 1'b0;
      char_err_q   <= 1'b0;
      rx_active_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      pat_q        <= pat_d;
      len_q        <= len_d;
      ovf_q        <= ovf_d;
      char_out_q   <= char_out_d;
      char_valid_q <= char_valid_d;
      char_err_q   <= char_err_d;
      rx_active_q  <= rx_active_d;
    end
  end

  // Next-state and output logic.
  always_comb begin
    state_d      = state_q;
    pat_d        = pat_q;
    len_d        = len_q;
    ovf_d        = ovf_q;
    char_out_d   = char_out_q;
    char_valid_d = 1'b0;
    char_err_d   = char_err_q;

    if (!ena) begin
      state_d = ST_IDLE;
      pat_d   = '0;
      len_d   = '0;
      ovf_d   = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (rise_c) state_d = ST_MARK;
        end
        ST_MARK: begin
          if (fall_c) begin
            if (len_q == LEN_MAX) begin
              ovf_d = 1'b1;
            end else begin
              pat_d[sym_idx] = (unit_cnt < DOT_LIMIT);
              len_d          = len_q + LEN_W'(1);
            end
            state_d = ST_SPACE;
          end
        end
        ST_SPACE: begin
          // A gap reaching the letter threshold wins even if the next mark
          // starts on the same cycle; that mark then opens a new letter.
          if (unit_tick_c && (unit_cnt == LETTER_PRE)) begin
            char_valid_d = 1'b1;
            char_out_d   = letter_code;
            char_err_d   = (letter_code == CHAR_ERR);
            pat_d        = '0;
            len_d        = '0;
            ovf_d        = 1'b0;
            state_d      = rise_c ? ST_MARK : ST_GAP;
          end else if (rise_c) begin
            state_d = ST_MARK;
          end
        end
        ST_GAP: begin
          if (rise_c) begin
            state_d = ST_MARK;
          end else if (unit_tick_c && (unit_cnt == WORD_PRE)) begin
            char_valid_d = 1'b1;
            char_out_d   = CHAR_SPACE;
            char_err_d   = 1'b0;
            state_d      = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    rx_active_d = (state_d == ST_MARK) || (state_d == ST_SPACE);
  end

  assign rx_if.char_out   = char_out_q;
  assign rx_if.char_valid = char_valid_q;
  assign rx_if.char_err   = char_err_q;
  assign rx_if.rx_active  = rx_active_q;

endmodule

// File: tb/tb_morse_rx_decoder.sv
// Directed bench for morse_rx_decoder with TIME_UNIT=4. Strobes are collected
// as {err,code} by a monitor on the falling clock edge and compared against
// hand-computed sequences. Build with MORSE_RX_GLITCH_FILTER_EN for the
// glitch-filter scenario (GLITCH_CYCLES=3).
module tb_morse_rx_decoder;

  localparam int unsigned TU = 4;

  logic clk      = 1'b0;
  logic rst_n    = 1'b0;
  logic ena      = 1'b0;
  logic morse_in = 1'b0;

  always #5 clk = ~clk;

  morse_rx_decoder_if rx_bus ();

  morse_rx_decoder #(
    .TIME_UNIT (TU)
`ifdef MORSE_RX_GLITCH_FILTER_EN
    ,
    .GLITCH_CYCLES (3)
`endif
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .ena      (ena),
    .morse_in (morse_in),
    .rx_if    (rx_bus)
  );

  int         checks = 0;
  int         errors = 0;
  int         dbl    = 0;
  logic       prev_v = 1'b0;
  logic [5:0] rxq[$];

  // Strobe monitor; also flags any strobe lasting more than one cycle.
  always @(negedge clk) begin
    if (rx_bus.char_valid) begin
      rxq.push_back({rx_bus.char_err, rx_bus.char_out});
      if (prev_v) dbl++;
    end
    prev_v = rx_bus.char_valid;
  end

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic key(input logic level, input int n);
    morse_in = level;
    repeat (n) @(negedge clk);
  endtask

  task automatic mark(input int n);
    key(1'b1, n);
  endtask

  task automatic space(input int n);
    key(1'b0, n);
  endtask

  // Compare strobe idx against {err,code}; a missing strobe reads as -1.
  task automatic chk_rx(input string tag, input int idx, input int code, input int err);
    int got;
    got = (idx < rxq.size()) ? int'(rxq[idx]) : -1;
    check(tag, got, err * 32 + code);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_char_out", int'(rx_bus.char_out), 0);
    check("rst_valid", int'(rx_bus.char_valid), 0);
    check("rst_err", int'(rx_bus.char_err), 0);
    check("rst_active", int'(rx_bus.rx_active), 0);
    rst_n = 1'b1;
    ena   = 1'b1;
    repeat (5) @(negedge clk);

    // A: .-
    rxq.delete();
    mark(4); space(4);
    morse_in = 1'b1;
    repeat (8) @(negedge clk);
    check("A_active", int'(rx_bus.rx_active), 1);
    repeat (4) @(negedge clk);
    space(60);
    check("A_count", rxq.size(), 2);
    chk_rx("A_letter", 0, 1, 0);
    chk_rx("A_space", 1, 0, 0);
    check("A_idle", int'(rx_bus.rx_active), 0);

    // B: -...
    rxq.delete();
    mark(12); space(4); mark(4); space(4); mark(4); space(4); mark(4); space(60);
    check("B_count", rxq.size(), 2);
    chk_rx("B_letter", 0, 2, 0);
    chk_rx("B_space", 1, 0, 0);

    // E, letter gap ending on the T rising edge, T, then one word space
    rxq.delete();
    mark(4); space(12); mark(12); space(40); space(20);
    check("ET_count", rxq.size(), 3);
    chk_rx("ET_E", 0, 5, 0);
    chk_rx("ET_T", 1, 20, 0);
    chk_rx("ET_space", 2, 0, 0);
    check("ET_hold", int'(rx_bus.char_out), 0);

    // Five dots overflow
    rxq.delete();
    repeat (4) begin mark(4); space(4); end
    mark(4); space(60);
    check("ovf_count", rxq.size(), 2);
    chk_rx("ovf_letter", 0, 31, 1);
    chk_rx("ovf_space", 1, 0, 0);

    // ..-- not in table
    rxq.delete();
    mark(4); space(4); mark(4); space(4); mark(12); space(4); mark(12); space(60);
    chk_rx("unk_letter", 0, 31, 1);
    chk_rx("unk_space", 1, 0, 0);

    // 11-cycle gap (unit_cnt 2) still intra-letter: .- = A
    rxq.delete();
    mark(4); space(11); mark(12); space(60);
    check("gap2_count", rxq.size(), 2);
    chk_rx("gap2_letter", 0, 1, 0);

`ifndef MORSE_RX_GLITCH_FILTER_EN
    // 1-cycle mark is a dot
    rxq.delete();
    mark(1); space(60);
    chk_rx("short_E", 0, 5, 0);
    chk_rx("short_space", 1, 0, 0);
`endif

    // ena low after a letter: no word space, char_out holds
    rxq.delete();
    mark(4); space(20);
    ena = 1'b0;
    repeat (10) @(negedge clk);
    ena = 1'b1;
    space(40);
    check("ena_count", rxq.size(), 1);
    chk_rx("ena_letter", 0, 5, 0);
    check("ena_hold_code", int'(rx_bus.char_out), 5);
    check("ena_hold_err", int'(rx_bus.char_err), 0);

    // Reset mid-mark of S discards the letter
    rxq.delete();
    mark(4); space(4); mark(4); space(4); mark(2);
    rst_n    = 1'b0;
    morse_in = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    space(40);
    check("rst_mid_count", rxq.size(), 0);
    check("rst_mid_code", int'(rx_bus.char_out), 0);
    check("rst_mid_err", int'(rx_bus.char_err), 0);
    check("rst_mid_active", int'(rx_bus.rx_active), 0);
    check("rst_mid_valid", int'(rx_bus.char_valid), 0);

`ifdef MORSE_RX_GLITCH_FILTER_EN
    // 2-cycle pulses are filtered out, a real E still decodes
    rxq.delete();
    repeat (3) begin mark(2); space(10); end
    check("glitch_count", rxq.size(), 0);
    check("glitch_active", int'(rx_bus.rx_active), 0);
    mark(4); space(60);
    chk_rx("glitch_E", 0, 5, 0);
    chk_rx("glitch_space", 1, 0, 0);
`endif

    check("valid_1cycle", dbl, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
